instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_loader.sv | 117 +++++++++++
 tb/tb_instr_mem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs low/high byte pairs into instruction words
// and writes them to instruction memory, flagging overflow and odd-length programs.
module instr_mem_loader #(
   parameter int DATA_WIDTH = 10,
   parameter int MEM_DEPTH  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  err_overflow,
   output logic                  err_odd,
   output logic                  cpu_start
);

   typedef enum logic [2:0] {IDLE, LO, HI, WRITE, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

   state_t     state, state_nxt;
   logic [7:0] lo_byte;
   logic       final_flag;
   logic       xfer;

   assign xfer = s_valid & s_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (arm) state_nxt = LO;
         LO:         if (xfer) state_nxt = s_last ? WRITE : HI;
         HI:         if (xfer) state_nxt = WRITE;
         WRITE: begin
            if (final_flag)                   state_nxt = DONE;
            else if (word_count == LAST_SLOT) state_nxt = DRAIN;
            else                              state_nxt = LO;
         end
         DRAIN:      if (xfer && s_last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready   = (state == LO) || (state == HI) || (state == DRAIN);
      busy      = (state != IDLE) && (state != DONE);
      load_done = (state == DONE);
      wr_en     = (state == WRITE);
   end

   // wr_addr/wr_data are only loaded on the transfer that enters WRITE,
   // so they hold the last written word at all other times.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_byte      <= '0;
         final_flag   <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         word_count   <= '0;
         err_overflow <= 1'b0;
         err_odd      <= 1'b0;
         cpu_start    <= 1'b0;
      end else begin
         cpu_start <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (arm) begin
                  word_count   <= '0;
                  err_overflow <= 1'b0;
                  err_odd      <= 1'b0;
               end
            end
            LO: begin
               if (xfer) begin
                  lo_byte <= s_data;
                  if (s_last) begin
                     wr_data    <= {{(DATA_WIDTH-8){1'b0}}, s_data};
                     wr_addr    <= word_count[ADDR_WIDTH-1:0];
                     final_flag <= 1'b1;
                     err_odd    <= 1'b1;
                  end
               end
            end
            HI: begin
               if (xfer) begin
                  wr_data    <= {s_data[DATA_WIDTH-9:0], lo_byte};
                  wr_addr    <= word_count[ADDR_WIDTH-1:0];
                  final_flag <= s_last;
               end
            end
            WRITE: begin
               word_count <= word_count + 1'b1;
               if (final_flag)
                  cpu_start <= !err_overflow && !err_odd;
               else if (word_count == LAST_SLOT)
                  err_overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a word-level
// model of the program format (byte pairs, odd tail, depth limit).
module tb_instr_mem_loader;

   localparam int DW = 10;
   localparam int MEM_DEPTH = 8;
   localparam int AW = 3;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          rst, arm, s_valid, s_last;
   logic [7:0]    s_data;
   logic          s_ready, wr_en, busy, load_done, err_overflow, err_odd, cpu_start;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   word_count;

   int checks = 0;
   int errors = 0;

   int got_q[$];
   int cs_cnt;
   int exp_q[$];
   int exp_wc;
   bit exp_ovf, exp_odd, exp_cs;

   instr_mem_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .load_done(load_done), .word_count(word_count),
      .err_overflow(err_overflow), .err_odd(err_odd), .cpu_start(cpu_start)
   );

   always #5 clk = ~clk;

   // Write/start monitor: every write is logged as addr*65536 + data.
   always @(negedge clk) begin
      if (wr_en) got_q.push_back(int'(wr_addr) * 65536 + int'(wr_data));
      if (cpu_start) cs_cnt++;
   end

   // Word-level model: bytes pair up low-first; a lone trailing byte is an
   // odd end; anything past MEM_DEPTH words is an overflow and is dropped.
   function automatic void model(input bq_t b);
      int i = 0;
      int lo, hi;
      exp_q.delete();
      exp_ovf = 0;
      exp_odd = 0;
      while (i < b.size()) begin
         if (exp_q.size() == MEM_DEPTH) begin
            exp_ovf = 1;
            break;
         end
         lo = int'(b[i]);
         if (i == b.size() - 1) begin
            exp_odd = 1;
            hi = 0;
            i += 1;
         end else begin
            hi = int'(b[i+1]) % (1 << (DW - 8));
            i += 2;
         end
         exp_q.push_back(exp_q.size() * 65536 + hi * 256 + lo);
      end
      exp_wc = exp_q.size();
      exp_cs = !exp_ovf && !exp_odd;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      got_q.delete();
      cs_cnt = 0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Presents one byte, optionally after random idle cycles; returns just after the transfer edge.
   task automatic push_byte(input logic [7:0] b, input logic last, input bit rnd);
      int guard = 0;
      while (rnd && $urandom_range(0, 2) == 0) begin
         s_valid = 1'b0;
         tick();
      end
      s_valid = 1'b1;
      s_data  = b;
      s_last  = last;
      forever begin
         @(negedge clk);
         if (s_ready) begin
            tick();
            break;
         end
         tick();
         guard++;
         if (guard > 50) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout got s_ready=0 need 1");
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (load_done) break;
         n++;
      end
      checks++;
      if (load_done !== 1'b1) begin
         errors++;
         $display("FAIL load_done_timeout got %b need 1", load_done);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_load(input bq_t b, input bit rnd);
      do_arm();
      foreach (b[i]) push_byte(b[i], i == b.size() - 1, rnd);
      wait_done();
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, wr_en, wr_addr, wr_data, busy, load_done, word_count, err_overflow, err_odd, cpu_start} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b we=%b a=%0d d=%h busy=%b done=%b wc=%0d need all 0",
                  s_ready, wr_en, wr_addr, wr_data, busy, load_done, word_count);
      end
      // Reset in the middle of a load (state HI) with arm held high.
      tick();
      do_arm();
      push_byte(8'h5A, 1'b0, 1'b0);
      rst = 1'b1; arm = 1'b1;
      repeat (2) tick();
      rst = 1'b0; arm = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, wr_en, busy, load_done, word_count, err_overflow, err_odd, cpu_start} !== '0) begin
         errors++;
         $display("FAIL reset_midload got rdy=%b we=%b busy=%b done=%b wc=%0d need all 0",
                  s_ready, wr_en, busy, load_done, word_count);
      end
      tick();
      do_arm();
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL arm_after_reset got rdy=%b busy=%b need 1 1", s_ready, busy);
      end
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_single_word();
      do_arm();
      push_byte(8'h34, 1'b0, 1'b0);
      push_byte(8'h02, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 10'h234) begin
         errors++;
         $display("FAIL single_write got we=%b a=%0d d=%h need 1 0 234", wr_en, wr_addr, wr_data);
      end
      wait_done();
      checks++;
      if (got_q.size() != 1 || word_count !== 4'd1 || cs_cnt != 1 || err_odd || err_overflow) begin
         errors++;
         $display("FAIL single_done got writes=%0d wc=%0d cs=%0d odd=%b ovf=%b need 1 1 1 0 0",
                  got_q.size(), word_count, cs_cnt, err_odd, err_overflow);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || wr_data !== 10'h234 || load_done !== 1'b1) begin
         errors++;
         $display("FAIL single_hold got we=%b d=%h done=%b need 0 234 1", wr_en, wr_data, load_done);
      end
   endtask

   task automatic test_full_program();
      bq_t b;
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      model(b);
      run_load(b, 1'b1);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL full_nwrites got %0d need %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
               errors++;
               $display("FAIL full_write%0d got %h need %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (word_count !== 4'd8 || err_overflow || err_odd || cs_cnt != 1) begin
         errors++;
         $display("FAIL full_status got wc=%0d ovf=%b odd=%b cs=%0d need 8 0 0 1",
                  word_count, err_overflow, err_odd, cs_cnt);
      end
   endtask

   task automatic test_overflow();
      bq_t b;
      for (int i = 0; i < 18; i++) b.push_back(8'($urandom));
      model(b);
      run_load(b, 1'b1);
      checks++;
      if (got_q.size() != MEM_DEPTH) begin
         errors++;
         $display("FAIL ovf_nwrites got %0d need %0d", got_q.size(), MEM_DEPTH);
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
               errors++;
               $display("FAIL ovf_write%0d got %h need %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (err_overflow !== 1'b1 || err_odd !== 1'b0 || cs_cnt != 0 || word_count !== 4'd8 || load_done !== 1'b1) begin
         errors++;
         $display("FAIL ovf_status got ovf=%b odd=%b cs=%0d wc=%0d done=%b need 1 0 0 8 1",
                  err_overflow, err_odd, cs_cnt, word_count, load_done);
      end
   endtask

   task automatic test_odd_end();
      bq_t b = '{8'h11, 8'h01, 8'hAB};
      run_load(b, 1'b0);
      checks++;
      if (got_q.size() != 2 || got_q[0] != 'h111 || got_q[1] != 65536 + 'h0AB) begin
         errors++;
         $display("FAIL odd_writes got n=%0d w0=%h w1=%h need 2 111 100ab",
                  got_q.size(), got_q.size() > 0 ? got_q[0] : -1, got_q.size() > 1 ? got_q[1] : -1);
      end
      checks++;
      if (err_odd !== 1'b1 || err_overflow !== 1'b0 || cs_cnt != 0 || word_count !== 4'd2) begin
         errors++;
         $display("FAIL odd_status got odd=%b ovf=%b cs=%0d wc=%0d need 1 0 0 2",
                  err_odd, err_overflow, cs_cnt, word_count);
      end
   endtask

   task automatic test_reset_mid_load();
      bq_t b;
      bq_t b2;
      logic [7:0] lo = 8'($urandom);
      for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
      model(b);
      do_arm();
      foreach (b[i]) push_byte(b[i], 1'b0, 1'b1);
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      checks++;
      if (got_q.size() != 3 || got_q[0] != exp_q[0] || got_q[2] != exp_q[2]) begin
         errors++;
         $display("FAIL midload_writes got n=%0d need 3", got_q.size());
      end
      b2 = '{lo, 8'hFE};
      run_load(b2, 1'b0);
      checks++;
      if (got_q.size() != 1 || got_q[0] != 512 + int'(lo)) begin
         errors++;
         $display("FAIL rearm_write got n=%0d w0=%h need 1 %h",
                  got_q.size(), got_q.size() > 0 ? got_q[0] : -1, 512 + int'(lo));
      end
      checks++;
      if (wr_data[9:8] !== 2'b10 || word_count !== 4'd1 || cs_cnt != 1) begin
         errors++;
         $display("FAIL rearm_status got hi=%b wc=%0d cs=%0d need 10 1 1", wr_data[9:8], word_count, cs_cnt);
      end
   endtask

   task automatic test_random_loads();
      for (int k = 0; k < 6; k++) begin
         bq_t b;
         int n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         model(b);
         run_load(b, 1'b1);
         checks++;
         if (got_q != exp_q) begin
            errors++;
            $display("FAIL rand%0d_writes got n=%0d need n=%0d (bytes=%0d)", k, got_q.size(), exp_q.size(), n);
         end
         checks++;
         if (int'(word_count) != exp_wc || err_overflow !== exp_ovf || err_odd !== exp_odd || cs_cnt != int'(exp_cs)) begin
            errors++;
            $display("FAIL rand%0d_status got wc=%0d ovf=%b odd=%b cs=%0d need %0d %b %b %0d",
                     k, word_count, err_overflow, err_odd, cs_cnt, exp_wc, exp_ovf, exp_odd, exp_cs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_program();
      test_overflow();
      test_odd_end();
      test_reset_mid_load();
      test_random_loads();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
